// File: rtl/imm_pkg.sv
// Shared mode encodings and default widths for the immediate extender.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_ZEXT     = 2'd0,
    IMM_SEXT     = 2'd1,
    IMM_SEXT_SEL = 2'd2,
    IMM_SEXT_SHL = 2'd3
  } imm_mode_e;

  localparam int IMM_IN_W = 10;
  localparam int DATA_W   = 16;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: zero/sign/selected-bit sign extension and
// sign-extend-then-shift with signed overflow detection.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = DATA_W,
  parameter int SHIFT = 1,
  parameter int MSB_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  data,
  input  logic [1:0]       mode,
  input  logic [MSB_W-1:0] msb,
  output logic [OUT_W-1:0] ext,
  output logic             ovf
);

  localparam int KW = $clog2(IN_W);
  localparam int WW = (OUT_W > IN_W + SHIFT) ? OUT_W : IN_W + SHIFT;

  logic [KW-1:0]           k;
  logic [OUT_W-1:0]        upper;
  logic signed [WW-1:0]    wide;
  logic signed [OUT_W-1:0] trunc;
  logic signed [WW-1:0]    back;

  always_comb begin
    // Sign position: top bit for mode 1, clamped runtime index for mode 2.
    if (imm_mode_e'(mode) == IMM_SEXT_SEL && 32'(msb) <= IN_W - 1) k = KW'(msb);
    else                                                         k = KW'(IN_W - 1);
    upper = {OUT_W{1'b1}} << k << 1;

    // Exact shifted value lives in WW bits; overflow if it does not survive truncation.
    wide  = WW'($signed(data));
    wide  = wide <<< SHIFT;
    trunc = wide[OUT_W-1:0];
    back  = WW'(trunc);

    ext = '0;
    ovf = 1'b0;
    unique case (imm_mode_e'(mode))
      IMM_ZEXT:     ext = OUT_W'(data);
      IMM_SEXT,
      IMM_SEXT_SEL: ext = (OUT_W'(data) & ~upper) | (data[k] ? upper : '0);
      IMM_SEXT_SHL: begin
        ext = trunc;
        ovf = (back != wide);
      end
      default:      ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: output register plus one skid register so a
// stalled consumer never drops or duplicates an item; in_ready is a flop.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = DATA_W,
  parameter int SHIFT = 1,
  parameter int MSB_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [MSB_W-1:0] in_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  logic [OUT_W-1:0] ext;
  logic             ovf;

  imm_extend_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT),
    .MSB_W(MSB_W)
  ) u_core (
    .data(in_data),
    .mode(in_mode),
    .msb (in_msb),
    .ext (ext),
    .ovf (ovf)
  );

  logic             or_vld_q, or_vld_d;
  logic [OUT_W-1:0] or_data_q, or_data_d;
  logic             or_ovf_q, or_ovf_d;
  logic             sk_vld_q, sk_vld_d;
  logic [OUT_W-1:0] sk_data_q, sk_data_d;
  logic             sk_ovf_q, sk_ovf_d;
  logic             acc, drn;

  assign acc = in_valid & ~sk_vld_q;
  assign drn = or_vld_q & out_ready;

  always_comb begin
    or_vld_d  = or_vld_q;
    or_data_d = or_data_q;
    or_ovf_d  = or_ovf_q;
    sk_vld_d  = sk_vld_q;
    sk_data_d = sk_data_q;
    sk_ovf_d  = sk_ovf_q;
    if (drn && sk_vld_q) begin
      // Skid full means in_ready is low, so no accept can coincide here.
      or_data_d = sk_data_q;
      or_ovf_d  = sk_ovf_q;
      sk_vld_d  = 1'b0;
    end else if (drn || !or_vld_q) begin
      or_vld_d = acc;
      if (acc) begin
        or_data_d = ext;
        or_ovf_d  = ovf;
      end
    end else if (acc) begin
      sk_vld_d  = 1'b1;
      sk_data_d = ext;
      sk_ovf_d  = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_vld_q  <= 1'b0;
      or_data_q <= '0;
      or_ovf_q  <= 1'b0;
      sk_vld_q  <= 1'b0;
      sk_data_q <= '0;
      sk_ovf_q  <= 1'b0;
    end else begin
      or_vld_q  <= or_vld_d;
      or_data_q <= or_data_d;
      or_ovf_q  <= or_ovf_d;
      sk_vld_q  <= sk_vld_d;
      sk_data_q <= sk_data_d;
      sk_ovf_q  <= sk_ovf_d;
    end
  end

  assign in_ready  = ~sk_vld_q;
  assign out_valid = or_vld_q;
  assign out_data  = or_data_q;
  assign out_ovf   = or_ovf_q;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender. It widens IN_W-bit instruction immediates to OUT_W-bit datapath words.
- Supported modes: zero-extend, sign-extend from the top bit, sign-extend from a runtime-selected bit, and sign-extend then shift left (branch/jump offsets).
- Sits between the instruction decoder and the ALU operand mux.
- Uses a valid/ready handshake with a 2-entry skid buffer, so decoder stalls never drop or duplicate an immediate.

Parameters:
- IN_W, 10, raw immediate width (2..32).
- OUT_W, 16, extended output width (≥ IN_W, ≤ 64).
- SHIFT, 1, left-shift amount applied in mode 3 (0..7).
- MSB_W, $clog2(IN_W), width of the runtime sign-bit index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_mode/in_msb are valid.
- in_ready  out  1  block can accept an item this cycle (registered).
- in_data  in  IN_W  raw immediate.
- in_mode  in  2  0=zero-ext, 1=sign-ext from bit IN_W-1, 2=sign-ext from bit in_msb, 3=sign-ext from bit IN_W-1 then << SHIFT.
- in_msb  in  MSB_W  sign-bit index for mode 2.
- out_valid  out  1  out_data/out_ovf are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  OUT_W  extended result.
- out_ovf  out  1  mode-3 result did not fit in OUT_W as a signed value.

Behaviour:
- Reset is synchronous: on a clk edge with rst=1:
  - out_valid=0, out_data=0, out_ovf=0, in_ready=1.
  - Skid entry cleared.
  - Any in-flight item is discarded, including one presented in the same cycle.
- Accept when in_valid & in_ready; deliver when out_valid & out_ready.
- Latency: an item accepted at edge N appears on out_* after edge N (1 cycle) when the output register is empty or draining.
- Extension is computed combinationally on accept; only the result is stored.
- Mode 0: upper OUT_W-IN_W bits = 0.
- Mode 1: upper bits = in_data[IN_W-1].
- Mode 2:
  - Let k = min(in_msb, IN_W-1).
  - Bits [k:0] are kept; bits above k in in_data are ignored.
  - All output bits above k = in_data[k].
- Mode 3:
  - r = sign_ext(in_data) << SHIFT, computed exactly in IN_W+SHIFT bits, then sign-extended or truncated to OUT_W.
  - out_ovf=1 iff the exact value is outside the signed OUT_W range. This is only possible when IN_W+SHIFT > OUT_W.
  - out_data = low OUT_W bits of r; low SHIFT bits are always 0.
- out_ovf is 0 in modes 0–2.
- Storage: output register (OR) plus one skid register (SK). FIFO order is OR then SK.
  - Accept with OR empty, or OR draining and SK empty → write OR.
  - Accept with OR full and not draining → write SK; in_ready drops to 0 next cycle.
  - OR drains with SK full → SK moves to OR; in_ready returns to 1 next cycle.
  - Accept and drain in the same cycle with SK empty → OR takes the new item; out_valid stays 1.
- in_ready depends only on SK occupancy, never combinationally on out_ready.
- out_data and out_ovf must be held stable while out_valid=1 and out_ready=0.
- Invariant: never more than 2 items held; no item is lost or duplicated.
- in_mode and in_msb are sampled only on accept.

Decomposition:
- Shared package imm_pkg:
  - Mode encodings IMM_ZEXT=0, IMM_SEXT=1, IMM_SEXT_SEL=2, IMM_SEXT_SHL=3.
  - Default widths IMM_IN_W=10, DATA_W=16.
- Sub-module imm_extend_core: purely combinational (data, mode, msb) → (ext, ovf), parametrised like the top.
- The top level holds only the OR/SK handshake logic.

Test Plan:
- IN_W=10, OUT_W=16, out_ready=1; send mode0 0x3FF, mode1 0x200, mode1 0x1FF → out_data 0x03FF, 0xFE00, 0x01FF, each 1 cycle after accept; ovf=0.
- Mode 2 with in_msb=8: data 0x100 → 0xFF00; data 0x2FF → 0x00FF (bit 9 ignored); in_msb=15 clamps to 9, so data 0x200 → 0xFE00.
- Mode 3, SHIFT=1: data 0x3FF → 0xFFFE, ovf=0. Separate instance IN_W=10, OUT_W=10, SHIFT=1: data 0x100 → 0x200 with ovf=1; data 0x080 → 0x100 with ovf=0.
- Backpressure: out_ready=0, send A=0x001, B=0x002, C=0x003 back-to-back in mode 0 → A and B accepted, in_ready=0 from the cycle after B is accepted, C held. Raise out_ready → order A, B, C with no gaps once flowing; out_data stable while stalled.
- Simultaneous events: OR full, SK empty, in_valid=1 and out_ready=1 in the same cycle → new item enters OR, out_valid stays 1, in_ready stays 1.
- Reset mid-operation: with OR and SK full, assert rst for 1 cycle while in_valid=1 → next cycle out_valid=0, out_data=0, in_ready=1; items sent after reset emerge correctly and nothing from before reset appears.
